// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of sig_in in clk cycles
// and reports lock once successive periods agree within TOL.
// Optional macro PERIOD_METER_SYNC_EN selects a two-flop input synchronizer;
// when undefined, sig_in is registered once and must be synchronous to clk.
module clk_period_meter #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 65535,
    parameter int LOCK_COUNT = 4,
    parameter int TOL        = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [3:0]       match_q, match_d;
    logic             mv_q, mv_d;
    logic             to_q, to_d;
    logic             prev_q, prev_d;
    logic             sig_s;
    logic             sig_d_q;
    logic             rise;
    logic [CNT_W-1:0] diff;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for an asynchronous sig_in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sig_in};
        end
    end

    assign sig_s = sync_q[1];
`else
    logic sync_q;

    // Single input register for a clk-synchronous sig_in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sig_in;
        end
    end

    assign sig_s = sync_q;
`endif

    // Delayed copy of the conditioned input for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_d_q <= 1'b0;
        end else begin
            sig_d_q <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d_q;

    // Unsigned distance between the running count and the last reported period.
    always_comb begin
        diff = (per_cnt_q >= period_q) ? (per_cnt_q - period_q) : (period_q - per_cnt_q);
    end

    // Next-state logic: arm on the first edge, report on each later edge, abort on timeout.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        match_d   = match_q;
        mv_d      = 1'b0;
        to_d      = to_q;
        prev_d    = prev_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = CNT_W'(1);
                    to_d      = 1'b0;
                    match_d   = '0;
                    prev_d    = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d  = per_cnt_q;
                    high_d    = hi_cnt_q;
                    mv_d      = 1'b1;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = CNT_W'(1);
                    prev_d    = 1'b1;
                    if (prev_q && (diff <= TOL_C)) begin
                        if (match_q < LOCK_C) begin
                            match_d = match_q + 4'd1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end else if (per_cnt_q == TIMEOUT_C) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    match_d = '0;
                    prev_d  = 1'b0;
                end else begin
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                    if (sig_s) begin
                        hi_cnt_d = hi_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and measurement registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            match_q   <= '0;
            mv_q      <= 1'b0;
            to_q      <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            match_q   <= match_d;
            mv_q      <= mv_d;
            to_q      <= to_d;
            prev_q    <= prev_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = (match_q == LOCK_C);
    assign timeout    = to_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: two instances (TOL=0 and TOL=1, TIMEOUT=20)
// share one stimulus; expected reports come from a hand-computed period table.
module tb_clk_period_meter;

    localparam int CNT_W = 16;
`ifdef PERIOD_METER_SYNC_EN
    localparam int IN_DLY = 2;
`else
    localparam int IN_DLY = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_a, high_a, period_b, high_b;
    logic             mv_a, locked_a, timeout_a;
    logic             mv_b, locked_b, timeout_b;

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(20), .LOCK_COUNT(4), .TOL(0)) u_a (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .period(period_a), .high_time(high_a),
        .meas_valid(mv_a), .locked(locked_a), .timeout(timeout_a)
    );

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(20), .LOCK_COUNT(4), .TOL(1)) u_b (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .period(period_b), .high_time(high_b),
        .meas_valid(mv_b), .locked(locked_b), .timeout(timeout_b)
    );

    // One table row per driven period; lk_* is the lock state expected when that period is reported.
    typedef struct {
        int unsigned per;
        int unsigned hi;
        bit          lk_a;
        bit          lk_b;
    } vec_t;

    vec_t        vecs[39];
    vec_t        q[$];
    vec_t        pend;
    bit          pend_v;
    bit          to_chk;
    int unsigned n_chk, n_fail, cyc, last_mv_cyc;

    function automatic vec_t mk(input int unsigned p, input int unsigned h, input bit a, input bit b);
        vec_t v;
        v.per  = p;
        v.hi   = h;
        v.lk_a = a;
        v.lk_b = b;
        return v;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compares every meas_valid pulse against the oldest outstanding table row.
    task automatic check_outputs();
        vec_t e;
        if (mv_a || mv_b) begin
            last_mv_cyc = cyc;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_meas_valid: got a=%0d b=%0d, expected 0 (cycle %0d)", mv_a, mv_b, cyc);
            end else begin
                e = q.pop_front();
                chk("meas_valid_a", mv_a, 1);
                chk("meas_valid_b", mv_b, 1);
                chk("period_a", period_a, e.per);
                chk("high_time_a", high_a, e.hi);
                chk("locked_a", locked_a, e.lk_a);
                chk("period_b", period_b, e.per);
                chk("high_time_b", high_b, e.hi);
                chk("locked_b", locked_b, e.lk_b);
            end
        end
        if (to_chk) begin
            chk("no_timeout_a", timeout_a, 0);
            chk("no_timeout_b", timeout_b, 0);
        end
    endtask

    task automatic tick(input logic v);
        @(negedge clk);
        cyc++;
        check_outputs();
        sig_in = v;
    endtask

    task automatic rise_push();
        if (pend_v) q.push_back(pend);
        pend_v = 1'b0;
    endtask

    task automatic run_entry(input int idx);
        rise_push();
        pend   = vecs[idx];
        pend_v = 1'b1;
        for (int unsigned i = 0; i < vecs[idx].per; i++) begin
            tick(i < vecs[idx].hi);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period_a"}, period_a, 0);
        chk({tag, "_high_a"}, high_a, 0);
        chk({tag, "_mv_a"}, mv_a, 0);
        chk({tag, "_locked_a"}, locked_a, 0);
        chk({tag, "_timeout_a"}, timeout_a, 0);
        chk({tag, "_period_b"}, period_b, 0);
        chk({tag, "_high_b"}, high_b, 0);
        chk({tag, "_mv_b"}, mv_b, 0);
        chk({tag, "_locked_b"}, locked_b, 0);
        chk({tag, "_timeout_b"}, timeout_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        int unsigned to_n;

        for (int i = 0; i <= 5; i++) vecs[i] = mk(8, 4, i >= 4, i >= 4);
        for (int i = 6; i <= 11; i++) vecs[i] = mk(10, 3, i >= 10, i >= 10);
        vecs[12] = mk(12, 3, 0, 0);
        for (int i = 13; i <= 17; i++) vecs[i] = mk(10, 3, i == 17, i == 17);
        vecs[18] = mk(8, 4, 0, 0);
        vecs[19] = mk(9, 4, 0, 0);
        vecs[20] = mk(8, 4, 0, 0);
        vecs[21] = mk(9, 4, 0, 0);
        vecs[22] = mk(8, 4, 0, 1);
        vecs[23] = mk(9, 4, 0, 1);
        vecs[24] = mk(8, 4, 0, 1);
        vecs[25] = mk(8, 4, 0, 1);
        vecs[26] = mk(8, 4, 0, 1);
        vecs[27] = mk(8, 4, 0, 1);
        vecs[28] = mk(8, 4, 1, 1);
        vecs[29] = mk(10, 5, 0, 0);
        vecs[30] = mk(8, 4, 0, 0);
        vecs[31] = mk(10, 5, 0, 0);
        vecs[32] = mk(8, 4, 0, 0);
        vecs[33] = mk(20, 10, 0, 0);
        vecs[34] = mk(8, 4, 0, 0);
        for (int i = 35; i <= 37; i++) vecs[i] = mk(8, 4, 0, 0);
        vecs[38] = mk(8, 4, 1, 1);

        n_chk = 0; n_fail = 0; cyc = 0; last_mv_cyc = 0;
        pend_v = 1'b0; to_chk = 1'b1;

        // Reset state.
        rst = 1'b0;
        repeat (3) tick(1'b0);
        check_zero("reset");
        rst = 1'b1;
        repeat (2) tick(1'b0);

        // Square wave lock, period step and relock, TOL=1 alternation, then lock on A.
        for (int i = 0; i <= 28; i++) run_entry(i);

        // Final rise then sig_in stays low: timeout when per_cnt reaches 20.
        rise_push();
        to_chk = 1'b0;
        tick(1'b1);
        c0 = cyc;
        repeat (3) tick(1'b1);
        to_n = 0;
        for (int n = 4; n <= 40 && to_n == 0; n++) begin
            tick(1'b0);
            if (timeout_a) to_n = cyc - c0;
        end
        chk("timeout_cycle", to_n, 21 + IN_DLY);
        chk("timeout_b", timeout_b, 1);
        chk("timeout_locked_a", locked_a, 0);
        chk("timeout_locked_b", locked_b, 0);
        chk("timeout_hold_period", period_a, 8);
        chk("timeout_hold_high", high_a, 4);
        repeat (3) tick(1'b0);
        chk("timeout_sticky", timeout_a, 1);

        // Next rise clears timeout but only arms.
        tick(1'b1);
        for (int n = 1; n < 4; n++) begin
            tick(1'b1);
            if (n == IN_DLY) chk("timeout_before_clear", timeout_a, 1);
            if (n == IN_DLY + 1) begin
                chk("timeout_cleared_a", timeout_a, 0);
                chk("timeout_cleared_b", timeout_b, 0);
            end
        end
        repeat (4) tick(1'b0);
        to_chk = 1'b1;
        pend   = mk(8, 4, 0, 0);
        pend_v = 1'b1;

        // 8/10 alternation, period exactly TIMEOUT, then lock again.
        for (int i = 29; i <= 38; i++) run_entry(i);

        // Reset mid-period while locked.
        rise_push();
        repeat (4) tick(1'b1);
        repeat (2) tick(1'b0);
        chk("pre_reset_locked_a", locked_a, 1);
        chk("pre_reset_locked_b", locked_b, 1);
        rst = 1'b0;
        tick(1'b0);
        check_zero("mid_reset");
        rst = 1'b1;
        pend_v = 1'b0;
        repeat (3) tick(1'b0);
        repeat (4) tick(1'b1);
        repeat (4) tick(1'b0);
        pend   = mk(8, 4, 0, 0);
        pend_v = 1'b1;

        // Second post-reset rise reports; measure edge-to-meas_valid latency
        // counted up to the edge where a downstream flop captures meas_valid.
        rise_push();
        last_mv_cyc = 0;
        tick(1'b1);
        c0 = cyc;
        repeat (3) tick(1'b1);
        repeat (4) tick(1'b0);
        chk("latency", last_mv_cyc - c0 + 1, IN_DLY + 2);
        repeat (6) tick(1'b0);
        chk("all_reports_seen", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
